// File: rtl/sha_target_check_pkg.sv
// Shared constants and helpers for the SHA-256 target checker.
// The byte_rev helper turns a raw digest into the value that is compared against the target.
package sha_target_check_pkg;

  localparam int WORD_S         = 32;
  localparam int H_SIZE         = 256;
  localparam int CHK_LAT        = 3;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int N_WORDS        = H_SIZE / WORD_S;

  // Byte d[7:0] lands in the top byte of the result.
  function automatic logic [H_SIZE-1:0] byte_rev(input logic [H_SIZE-1:0] d);
    logic [H_SIZE-1:0] r;
    r = '0;
    for (int i = 0; i < H_SIZE / 8; i++) begin
      r[H_SIZE-1-8*i -: 8] = d[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/sha_target_check_if.sv
// Digest input stream and golden-nonce output stream of the target checker.
// The master is the upstream pipeline plus the software drain side; the slave is the checker.
interface sha_target_check_if #(
  parameter int WORD_S = 32,
  parameter int H_SIZE = 256
);
  logic              en;
  logic [H_SIZE-1:0] H;
  logic [WORD_S-1:0] nonce;
  logic              found_valid;
  logic [WORD_S-1:0] found_nonce;
  logic              found_rd;

  modport master (
    output en, H, nonce, found_rd,
    input  found_valid, found_nonce
  );

  modport slave (
    input  en, H, nonce, found_rd,
    output found_valid, found_nonce
  );
endinterface

// File: rtl/sha_target_check_nonce_fifo.sv
// Small synchronous FIFO for golden nonces.
// Pop and push may happen in the same cycle even when the FIFO is full; a push into a full FIFO without a pop is dropped.
module nonce_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             wr,
  input  logic [W-1:0]     wdata,
  input  logic             rd,
  output logic [W-1:0]     rdata,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count,
  output logic             drop
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             rd_ok;
  logic             wr_ok;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign rd_ok = rd && !empty;
  // A pop frees the slot, so a full FIFO still accepts a push in the same cycle.
  assign wr_ok = wr && (!full || rd_ok);
  assign drop  = wr && full && !rd_ok;
  assign rdata = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(wr_ok) - CNT_W'(rd_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !clear) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/sha_target_check.sv
// Compares each byte-reversed SHA-256 digest against a difficulty target and queues winning nonces.
// Also keeps a 64-bit hashes-checked counter and a sticky FIFO overflow flag.
module sha_target_check
  import sha_target_check_pkg::*;
#(
  parameter int WORD_S     = sha_target_check_pkg::WORD_S,
  parameter int H_SIZE     = sha_target_check_pkg::H_SIZE,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 clear,
  input  logic [H_SIZE-1:0]    target,
  output logic [CNT_W-1:0]     found_count,
  output logic                 overflow,
  output logic [63:0]          hash_count,
  sha_target_check_if.slave    bus
);

  localparam int NW = H_SIZE / WORD_S;

  logic              accept;
  logic [H_SIZE-1:0] v_s1;
  logic [WORD_S-1:0] nonce_s1;
  logic              vld_s1;
  logic [NW-1:0]     lt_c;
  logic [NW-1:0]     eq_c;
  logic [NW-1:0]     lt_s2;
  logic [NW-1:0]     eq_s2;
  logic [WORD_S-1:0] nonce_s2;
  logic              vld_s2;
  logic              hit_c;
  logic              hit_s3;
  logic [WORD_S-1:0] nonce_s3;
  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_drop;

  assign accept = bus.en && run;

  always_comb begin
    lt_c = '0;
    eq_c = '0;
    for (int i = 0; i < NW; i++) begin
      lt_c[i] = v_s1[i*WORD_S +: WORD_S] <  target[i*WORD_S +: WORD_S];
      eq_c[i] = v_s1[i*WORD_S +: WORD_S] == target[i*WORD_S +: WORD_S];
    end
  end

  // The most significant non-equal word decides; all-equal counts as a hit.
  always_comb begin
    logic decided;
    hit_c   = 1'b1;
    decided = 1'b0;
    for (int i = NW - 1; i >= 0; i--) begin
      if (!decided && !eq_s2[i]) begin
        hit_c   = lt_s2[i];
        decided = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_s1     <= 1'b0;
      vld_s2     <= 1'b0;
      hit_s3     <= 1'b0;
      v_s1       <= '0;
      nonce_s1   <= '0;
      lt_s2      <= '0;
      eq_s2      <= '0;
      nonce_s2   <= '0;
      nonce_s3   <= '0;
      hash_count <= '0;
    end else if (clear) begin
      vld_s1     <= 1'b0;
      vld_s2     <= 1'b0;
      hit_s3     <= 1'b0;
      hash_count <= '0;
    end else begin
      vld_s1 <= accept;
      if (accept) begin
        v_s1       <= byte_rev(bus.H);
        nonce_s1   <= bus.nonce;
        hash_count <= hash_count + 64'd1;
      end
      vld_s2   <= vld_s1;
      lt_s2    <= lt_c;
      eq_s2    <= eq_c;
      nonce_s2 <= nonce_s1;
      hit_s3   <= vld_s2 && hit_c;
      nonce_s3 <= nonce_s2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (clear) begin
      overflow <= 1'b0;
    end else if (fifo_drop) begin
      overflow <= 1'b1;
    end
  end

  nonce_fifo #(
    .W     (WORD_S),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .wr    (hit_s3),
    .wdata (nonce_s3),
    .rd    (bus.found_rd),
    .rdata (bus.found_nonce),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (found_count),
    .drop  (fifo_drop)
  );

  assign bus.found_valid = !fifo_empty;

endmodule

// File: tb/tb_sha_target_check.sv
// Directed bench for sha_target_check: hit/miss boundaries, latency, FIFO full/overflow, clear and async reset.
module tb_sha_target_check;

  localparam int WS = 32;
  localparam int HS = 256;

  logic          clk;
  logic          reset;
  logic          run;
  logic          clear;
  logic [HS-1:0] target;
  logic [2:0]    found_count;
  logic          overflow;
  logic [63:0]   hash_count;

  int n_checks = 0;
  int n_fail   = 0;

  sha_target_check_if #(.WORD_S(WS), .H_SIZE(HS)) bus ();

  sha_target_check #(.WORD_S(WS), .H_SIZE(HS), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .clear       (clear),
    .target      (target),
    .found_count (found_count),
    .overflow    (overflow),
    .hash_count  (hash_count),
    .bus         (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [HS-1:0] rev(input logic [HS-1:0] v);
    logic [HS-1:0] r;
    for (int i = 0; i < HS / 8; i++) r[8*i +: 8] = v[HS-1-8*i -: 8];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [HS-1:0] h, input logic [WS-1:0] n);
    bus.H     = h;
    bus.nonce = n;
    bus.en    = 1'b1;
    tick();
    bus.en    = 1'b0;
  endtask

  task automatic pop();
    bus.found_rd = 1'b1;
    tick();
    bus.found_rd = 1'b0;
  endtask

  task automatic check_hit(input string tag, input logic [HS-1:0] h, input logic [WS-1:0] n, input logic exp);
    send(h, n);
    repeat (3) tick();
    check_val(tag, 64'(bus.found_valid), 64'(exp));
    if (exp) begin
      check_val({tag, "_nonce"}, 64'(bus.found_nonce), 64'(n));
      pop();
    end
  endtask

  logic [HS-1:0] t1;
  logic [HS-1:0] t2;

  initial begin
    reset        = 1'b1;
    run          = 1'b0;
    clear        = 1'b0;
    target       = '0;
    bus.en       = 1'b0;
    bus.H        = '0;
    bus.nonce    = '0;
    bus.found_rd = 1'b0;
    repeat (2) tick();
    check_val("rst_valid", 64'(bus.found_valid), 64'd0);
    check_val("rst_count", 64'(found_count), 64'd0);
    check_val("rst_nonce", 64'(bus.found_nonce), 64'd0);
    check_val("rst_ovf", 64'(overflow), 64'd0);
    check_val("rst_hash", hash_count, 64'd0);
    reset = 1'b0;
    tick();

    // all-ones target: every digest wins, FIFO overflows after four
    target = '1;
    run    = 1'b1;
    for (int i = 0; i < 10; i++) send(256'h1234 + 256'(i), 32'(i));
    repeat (3) tick();
    check_val("burst_hash", hash_count, 64'd10);
    check_val("burst_count", 64'(found_count), 64'd4);
    check_val("burst_ovf", 64'(overflow), 64'd1);
    for (int i = 0; i < 4; i++) begin
      check_val("burst_drain_vld", 64'(bus.found_valid), 64'd1);
      check_val("burst_drain_nonce", 64'(bus.found_nonce), 64'(i));
      pop();
    end
    check_val("burst_empty", 64'(bus.found_valid), 64'd0);
    check_val("burst_ovf_sticky", 64'(overflow), 64'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_val("clr_ovf", 64'(overflow), 64'd0);
    check_val("clr_hash", hash_count, 64'd0);

    // zero target
    target = '0;
    check_hit("zero_eq", 256'h0, 32'hA0, 1'b1);
    check_hit("zero_gt", 256'h1, 32'hA1, 1'b0);

    // equality boundary
    t1 = {32'h0, 32'h0000FFFF, 192'h0};
    target = t1;
    check_hit("eq_hit", rev(t1), 32'hB0, 1'b1);
    check_hit("eq_plus1", rev(t1 + 256'd1), 32'hB1, 1'b0);
    check_hit("w6_lt_dominates", rev({32'h0, 32'h0000FFFE, 64'h0, 32'hFFFFFFFF, 96'h0}), 32'hB2, 1'b1);
    t2 = t1 | (256'h100 << 96);
    target = t2;
    check_hit("w3_lt", rev(t1 | (256'hFF << 96)), 32'hB3, 1'b1);
    check_hit("w3_gt", rev(t1 | (256'h101 << 96)), 32'hB4, 1'b0);
    check_val("hash_mid", hash_count, 64'd7);

    // latency: valid at edge N, found_valid after edge N+3
    target = '1;
    send(256'h55, 32'hC0);
    tick();
    check_val("lat_n1", 64'(bus.found_valid), 64'd0);
    tick();
    check_val("lat_n2", 64'(bus.found_valid), 64'd0);
    tick();
    check_val("lat_n3", 64'(bus.found_valid), 64'd1);
    check_val("lat_nonce", 64'(bus.found_nonce), 64'hC0);
    pop();

    // run dropped mid-stream: in-flight entry completes, new valid ignored
    bus.H     = 256'h77;
    bus.nonce = 32'h300;
    bus.en    = 1'b1;
    tick();
    run       = 1'b0;
    bus.nonce = 32'h301;
    tick();
    bus.en = 1'b0;
    repeat (2) tick();
    check_val("run_off_count", 64'(found_count), 64'd1);
    check_val("run_off_nonce", 64'(bus.found_nonce), 64'h300);
    check_val("run_off_hash", hash_count, 64'd9);
    pop();
    repeat (3) tick();
    check_val("run_off_empty", 64'(bus.found_valid), 64'd0);
    run = 1'b1;

    // full FIFO with simultaneous hit and pop
    for (int i = 0; i < 4; i++) send(256'h9, 32'(100 + i));
    repeat (3) tick();
    check_val("full_count", 64'(found_count), 64'd4);
    send(256'h9, 32'd104);
    repeat (2) tick();
    bus.found_rd = 1'b1;
    tick();
    bus.found_rd = 1'b0;
    check_val("full_rw_count", 64'(found_count), 64'd4);
    check_val("full_rw_ovf", 64'(overflow), 64'd0);
    for (int i = 0; i < 4; i++) begin
      check_val("full_rw_nonce", 64'(bus.found_nonce), 64'(101 + i));
      pop();
    end
    check_val("full_rw_empty", 64'(bus.found_valid), 64'd0);

    // clear with half-full FIFO and hits in flight
    send(256'h9, 32'd200);
    send(256'h9, 32'd201);
    repeat (3) tick();
    check_val("half_count", 64'(found_count), 64'd2);
    bus.H     = 256'h9;
    bus.en    = 1'b1;
    bus.nonce = 32'd202;
    tick();
    bus.nonce = 32'd203;
    tick();
    bus.nonce = 32'd204;
    clear     = 1'b1;
    tick();
    clear  = 1'b0;
    bus.en = 1'b0;
    check_val("clr_count", 64'(found_count), 64'd0);
    check_val("clr_valid", 64'(bus.found_valid), 64'd0);
    check_val("clr_nonce", 64'(bus.found_nonce), 64'd0);
    check_val("clr_hash2", hash_count, 64'd0);
    repeat (4) tick();
    check_val("clr_no_late", 64'(bus.found_valid), 64'd0);
    check_val("clr_hash_late", hash_count, 64'd0);

    // asynchronous reset mid-cycle
    for (int i = 0; i < 5; i++) send(256'h9, 32'(400 + i));
    repeat (3) tick();
    check_val("pre_rst_count", 64'(found_count), 64'd4);
    check_val("pre_rst_ovf", 64'(overflow), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check_val("arst_valid", 64'(bus.found_valid), 64'd0);
    check_val("arst_count", 64'(found_count), 64'd0);
    check_val("arst_ovf", 64'(overflow), 64'd0);
    check_val("arst_hash", hash_count, 64'd0);
    tick();
    reset = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
